// File: rtl/fw_ctrl.sv
// Three-phase row-streaming controller: reads rows, feeds a pipelined kernel, buffers and writes
// back results. Define FW_CTRL_OVF_CHECK_EN to detect and drop results pushed into a full FIFO.
`timescale 1ns/1ps
`ifndef L
`define L 4
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

module fw_ctrl #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [AW-1:0]            nrows,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [AW-1:0]            rd_addr,
  input  logic [`L*`WIDTH-1:0]     rd_data,
  output logic [`L*`WIDTH-1:0]     k_inD,
  output logic                     k_in_valid,
  output logic [1:0]               k_phase,
  output logic                     k_enable,
  output logic                     k_inhibit,
  input  logic [`L*`WIDTH-1:0]     k_outD,
  input  logic                     k_out_valid,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [`L*`WIDTH-1:0]     wr_data,
  input  logic                     wr_ready,
  output logic                     ovf
);

  localparam int unsigned DW = `L*`WIDTH;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

  state_e          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic [AW-1:0]   nrows_q, nrows_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic            done_q, done_d;
  logic            rd_en_d1_q;
  logic            kin_valid_q;
  logic [DW-1:0]   kin_data_q;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;
  logic            push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign rd_en      = (state_q == StIssue) && (outst_q < CW'(DEPTH));
  assign rd_addr    = rd_addr_q;
  assign k_inD      = kin_data_q;
  assign k_in_valid = kin_valid_q && ((state_q == StIssue) || (state_q == StDrain));
  assign k_phase    = phase_q;
  assign k_enable   = busy;
  assign k_inhibit  = (state_q == StDrain);
  assign wr_en      = (cnt_q != '0);
  assign wr_addr    = wr_addr_q;
  assign wr_data    = mem_q[rptr_q];
  assign pop        = wr_en && wr_ready;

`ifdef FW_CTRL_OVF_CHECK_EN
  logic ovf_q;
  logic full;
  assign full = (cnt_q == CW'(DEPTH));
  assign push = k_out_valid && !full;
  assign ovf  = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (k_out_valid && full) begin
      ovf_q <= 1'b1;
    end
  end
`else
  assign push = k_out_valid;
  assign ovf  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    nrows_d   = nrows_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = pop ? wr_addr_q + AW'(1) : wr_addr_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          nrows_d   = nrows;
          phase_d   = 2'd0;
          rd_addr_d = '0;
          wr_addr_d = '0;
          state_d   = (nrows == '0) ? StFinish : StIssue;
        end
      end
      StIssue: begin
        if (rd_en) begin
          rd_addr_d = rd_addr_q + AW'(1);
          if (rd_addr_q == nrows_q - AW'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // Every row of the phase has been written back once wr_addr reaches nrows.
        if (wr_addr_q == nrows_q) begin
          rd_addr_d = '0;
          wr_addr_d = '0;
          if (phase_q == 2'd2) begin
            state_d = StFinish;
          end else begin
            phase_d = phase_q + 2'd1;
            state_d = StIssue;
          end
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        phase_d = 2'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    if (rd_en && !pop) outst_d = outst_q + CW'(1);
    else if (!rd_en && pop) outst_d = outst_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      phase_q     <= 2'd0;
      nrows_q     <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      outst_q     <= '0;
      done_q      <= 1'b0;
      rd_en_d1_q  <= 1'b0;
      kin_valid_q <= 1'b0;
      kin_data_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      nrows_q     <= nrows_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      outst_q     <= outst_d;
      done_q      <= done_d;
      rd_en_d1_q  <= rd_en;
      kin_valid_q <= rd_en_d1_q;
      if (rd_en_d1_q) kin_data_q <= rd_data;
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (push && !pop) cnt_q <= cnt_q + CW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= k_outD;
  end

endmodule
